// File: rtl/char_box_overlay_if.sv
// RGB565 video stream bundle: frame sync, line valid, pixel strobe and pixel data.
// The producer drives through master, the consumer samples through slave; there is no backpressure path.
interface char_box_overlay_if;
  logic        vsync;
  logic        href;
  logic        clken;
  logic [15:0] data;

  modport master (
    output vsync,
    output href,
    output clken,
    output data
  );

  modport slave (
    input vsync,
    input href,
    input clken,
    input data
  );
endinterface

// File: rtl/char_box_overlay.sv
// Draws a BOX_COLOR outline around up to seven segmented characters on an RGB565 stream.
// Data and syncs are delayed exactly 2 clk; there is no backpressure, every clk is registered so clken gaps pass through.
module char_box_overlay #(
  parameter logic [9:0]  IMG_HDISP = 10'd640,
  parameter logic [9:0]  IMG_VDISP = 10'd480,
  parameter int          LINE_W    = 2,
  parameter logic [15:0] BOX_COLOR = 16'hF800
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      overlay_en,
  char_box_overlay_if.slave         per_frame,
  input  logic [9:0]                vertical_start,
  input  logic [9:0]                vertical_end,
  input  logic [69:0]               char_line_left,
  input  logic [69:0]               char_line_right,
  char_box_overlay_if.master        post_frame,
  output logic [2:0]                box_valid_cnt
);

  localparam int          NBOX  = 7;
  localparam logic [10:0] LW_M1 = 11'(LINE_W - 1);
  localparam logic [9:0]  CMAX  = 10'h3FF;

  logic            vsync_d;
  logic            href_d;
  logic            vs_rise;
  logic            href_fall;

  logic            en_l;
  logic [9:0]      top_l;
  logic [9:0]      bot_l;
  logic [69:0]     left_l;
  logic [69:0]     right_l;
  logic [NBOX-1:0] valid_l;
  logic [NBOX-1:0] valid_nxt;

  logic [9:0]      x_cnt;
  logic [9:0]      y_cnt;

  logic [10:0]     x11;
  logic [10:0]     y11;
  logic [10:0]     t11;
  logic [10:0]     b11;
  logic [10:0]     l11;
  logic [10:0]     r11;
  logic            in_x;
  logic            in_y;
  logic            hband;
  logic            vband;
  logic            hit_nxt;

  logic            s1_vsync;
  logic            s1_href;
  logic            s1_clken;
  logic            s1_hit;
  logic [15:0]     s1_data;
  logic            s2_vsync;
  logic            s2_href;
  logic            s2_clken;
  logic [15:0]     s2_data;

  function automatic logic [2:0] popcount7(input logic [NBOX-1:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < NBOX; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

  assign vs_rise   = per_frame.vsync & ~vsync_d;
  assign href_fall = href_d & ~per_frame.href;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_d <= 1'b0;
      href_d  <= 1'b0;
    end else begin
      vsync_d <= per_frame.vsync;
      href_d  <= per_frame.href;
    end
  end

  always_comb begin
    valid_nxt = '0;
    for (int k = 0; k < NBOX; k++) begin
      valid_nxt[k] = (char_line_left[10*k +: 10] < char_line_right[10*k +: 10]) &&
                     (char_line_right[10*k +: 10] < IMG_HDISP) &&
                     (vertical_start < vertical_end) &&
                     (vertical_end < IMG_VDISP);
    end
  end

  // Geometry is frozen for the whole frame so upstream updates cannot tear a box mid-frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_l    <= 1'b0;
      top_l   <= '0;
      bot_l   <= '0;
      left_l  <= '0;
      right_l <= '0;
      valid_l <= '0;
    end else if (vs_rise) begin
      en_l    <= overlay_en;
      top_l   <= vertical_start;
      bot_l   <= vertical_end;
      left_l  <= char_line_left;
      right_l <= char_line_right;
      valid_l <= valid_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      box_valid_cnt <= 3'd0;
    end else begin
      box_valid_cnt <= en_l ? popcount7(valid_l) : 3'd0;
    end
  end

  // Coordinates of the pixel currently presented with clken; both saturate rather than wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_cnt <= '0;
    end else if (href_fall) begin
      x_cnt <= '0;
    end else if (per_frame.clken && x_cnt != CMAX) begin
      x_cnt <= x_cnt + 10'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_cnt <= '0;
    end else if (vs_rise) begin
      y_cnt <= '0;
    end else if (href_fall && y_cnt != CMAX) begin
      y_cnt <= y_cnt + 10'd1;
    end
  end

  // Bands are tested as y+LINE_W-1 >= B rather than y >= B-LINE_W+1 so nothing can underflow.
  always_comb begin
    x11     = {1'b0, x_cnt};
    y11     = {1'b0, y_cnt};
    t11     = {1'b0, top_l};
    b11     = {1'b0, bot_l};
    l11     = '0;
    r11     = '0;
    in_x    = 1'b0;
    in_y    = 1'b0;
    hband   = 1'b0;
    vband   = 1'b0;
    hit_nxt = 1'b0;
    for (int k = 0; k < NBOX; k++) begin
      l11   = {1'b0, left_l[10*k +: 10]};
      r11   = {1'b0, right_l[10*k +: 10]};
      in_x  = (x11 >= l11) && (x11 <= r11);
      in_y  = (y11 >= t11) && (y11 <= b11);
      hband = in_x && (((y11 >= t11) && (y11 <= t11 + LW_M1)) ||
                       ((y11 <= b11) && (y11 + LW_M1 >= b11)));
      vband = in_y && (((x11 >= l11) && (x11 <= l11 + LW_M1)) ||
                       ((x11 <= r11) && (x11 + LW_M1 >= r11)));
      if (valid_l[k] && (hband || vband)) begin
        hit_nxt = 1'b1;
      end
    end
    hit_nxt = hit_nxt & per_frame.clken;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vsync <= 1'b0;
      s1_href  <= 1'b0;
      s1_clken <= 1'b0;
      s1_hit   <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_vsync <= per_frame.vsync;
      s1_href  <= per_frame.href;
      s1_clken <= per_frame.clken;
      s1_hit   <= hit_nxt;
      s1_data  <= per_frame.data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_vsync <= 1'b0;
      s2_href  <= 1'b0;
      s2_clken <= 1'b0;
      s2_data  <= '0;
    end else begin
      s2_vsync <= s1_vsync;
      s2_href  <= s1_href;
      s2_clken <= s1_clken;
      s2_data  <= (s1_hit && en_l) ? BOX_COLOR : s1_data;
    end
  end

  assign post_frame.vsync = s2_vsync;
  assign post_frame.href  = s2_href;
  assign post_frame.clken = s2_clken;
  assign post_frame.data  = s2_data;

endmodule

// File: tb/tb_char_box_overlay.sv
// Directed bench for char_box_overlay on a 16x8 image; LINE_W=1 and LINE_W=2 instances share one input stream.
module tb_char_box_overlay;
  localparam logic [9:0]  HD  = 10'd16;
  localparam logic [9:0]  VD  = 10'd8;
  localparam logic [15:0] BOX = 16'hF800;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        overlay_en      = 1'b0;
  logic [9:0]  vertical_start  = '0;
  logic [9:0]  vertical_end    = '0;
  logic [69:0] char_line_left  = '0;
  logic [69:0] char_line_right = '0;
  logic [2:0]  cnt1;
  logic [2:0]  cnt2;

  char_box_overlay_if in_if ();
  char_box_overlay_if out1_if ();
  char_box_overlay_if out2_if ();

  char_box_overlay #(.IMG_HDISP(HD), .IMG_VDISP(VD), .LINE_W(1), .BOX_COLOR(BOX)) dut1 (
    .clk(clk), .rst(rst), .overlay_en(overlay_en), .per_frame(in_if),
    .vertical_start(vertical_start), .vertical_end(vertical_end),
    .char_line_left(char_line_left), .char_line_right(char_line_right),
    .post_frame(out1_if), .box_valid_cnt(cnt1)
  );

  char_box_overlay #(.IMG_HDISP(HD), .IMG_VDISP(VD), .LINE_W(2), .BOX_COLOR(BOX)) dut2 (
    .clk(clk), .rst(rst), .overlay_en(overlay_en), .per_frame(in_if),
    .vertical_start(vertical_start), .vertical_end(vertical_end),
    .char_line_left(char_line_left), .char_line_right(char_line_right),
    .post_frame(out2_if), .box_valid_cnt(cnt2)
  );

  int checks   = 0;
  int failures = 0;
  int lat_err  = 0;
  int ok_cnt   = 0;

  logic [15:0] img1 [8][16];
  logic [15:0] img2 [8][16];
  logic [43:0] rst_snap;

  logic        h1_vs = 1'b0, h1_hr = 1'b0, h1_ce = 1'b0;
  logic        h2_vs = 1'b0, h2_hr = 1'b0, h2_ce = 1'b0;
  int          h1_x = 0, h1_y = 0, h2_x = 0, h2_y = 0;

  function automatic logic [15:0] pix(input int x, input int y);
    return 16'h1000 | 16'(y << 4) | 16'(x);
  endfunction

  function automatic bit rc(input int x, input int y, input int x0, input int x1, input int y0, input int y1);
    return (x >= x0) && (x <= x1) && (y >= y0) && (y <= y1);
  endfunction

  // One clk of stimulus; outputs seen now belong to the input applied two steps ago.
  task automatic step(input logic vs, input logic hr, input logic ce, input int x, input int y);
    @(posedge clk);
    #1;
    rst         = 1'b0;
    in_if.vsync = vs;
    in_if.href  = hr;
    in_if.clken = ce;
    in_if.data  = ce ? pix(x, y) : 16'h0BAD;
    ok_cnt++;
    if (ok_cnt >= 3) begin
      if (out1_if.vsync !== h2_vs || out1_if.href !== h2_hr || out1_if.clken !== h2_ce ||
          out2_if.vsync !== h2_vs || out2_if.href !== h2_hr || out2_if.clken !== h2_ce)
        lat_err++;
      if (h2_ce && out1_if.clken) begin
        img1[h2_y][h2_x] = out1_if.data;
        img2[h2_y][h2_x] = out2_if.data;
      end
    end
    h2_vs = h1_vs; h2_hr = h1_hr; h2_ce = h1_ce; h2_x = h1_x; h2_y = h1_y;
    h1_vs = vs;    h1_hr = hr;    h1_ce = ce;    h1_x = x;    h1_y = y;
  endtask

  task automatic run_frame(input int chg_line, input logic [9:0] chg_left, input int rst_line);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 16; x++) begin
        img1[y][x] = 16'hDEAD;
        img2[y][x] = 16'hDEAD;
      end
    repeat (2) step(1'b0, 1'b0, 1'b0, 0, 0);
    repeat (3) step(1'b1, 1'b0, 1'b0, 0, 0);
    repeat (2) step(1'b0, 1'b0, 1'b0, 0, 0);
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 16; x++) begin
        if (y == chg_line && x == 4) char_line_left[9:0] = chg_left;
        if (y == rst_line && x == 8) begin
          #3;
          rst    = 1'b1;
          ok_cnt = 0;
          #1;
          rst_snap = {out1_if.vsync, out1_if.href, out1_if.clken, out1_if.data, cnt1,
                      out2_if.vsync, out2_if.href, out2_if.clken, out2_if.data, cnt2};
        end
        if ((y % 2) == 1 && x == 8) step(1'b0, 1'b1, 1'b0, 0, 0);
        step(1'b0, 1'b1, 1'b1, x, y);
      end
      repeat (3) step(1'b0, 1'b0, 1'b0, 0, 0);
    end
    repeat (3) step(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic set_box1(input logic en, input logic [9:0] l, input logic [9:0] r);
    overlay_en      = en;
    vertical_start  = 10'd1;
    vertical_end    = 10'd6;
    char_line_left  = '0;
    char_line_right = '0;
    char_line_left[9:0]  = l;
    char_line_right[9:0] = r;
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #2;
    checks++; if ({out1_if.vsync, out1_if.href, out1_if.clken} !== 3'b000) begin failures++; $display("FAIL reset_ctl1 got=%b exp=000", {out1_if.vsync, out1_if.href, out1_if.clken}); end
    checks++; if (out1_if.data !== 16'h0000) begin failures++; $display("FAIL reset_dat1 got=%h exp=0000", out1_if.data); end
    checks++; if (cnt1 !== 3'd0) begin failures++; $display("FAIL reset_cnt1 got=%0d exp=0", cnt1); end
    checks++; if ({out2_if.vsync, out2_if.href, out2_if.clken} !== 3'b000) begin failures++; $display("FAIL reset_ctl2 got=%b exp=000", {out2_if.vsync, out2_if.href, out2_if.clken}); end
    checks++; if (out2_if.data !== 16'h0000) begin failures++; $display("FAIL reset_dat2 got=%h exp=0000", out2_if.data); end
    checks++; if (cnt2 !== 3'd0) begin failures++; $display("FAIL reset_cnt2 got=%0d exp=0", cnt2); end
    repeat (4) step(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_geometry;
    logic [15:0] e1, e2;
    set_box1(1'b1, 10'd2, 10'd5);
    lat_err = 0;
    run_frame(-1, 10'd0, -1);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 16; x++) begin
        e1 = (rc(x, y, 2, 5, 1, 1) || rc(x, y, 2, 5, 6, 6) || rc(x, y, 2, 2, 1, 6) || rc(x, y, 5, 5, 1, 6)) ? BOX : pix(x, y);
        e2 = rc(x, y, 2, 5, 1, 6) ? BOX : pix(x, y);
        checks++; if (img1[y][x] !== e1) begin failures++; $display("FAIL geom_lw1 x=%0d y=%0d got=%h exp=%h", x, y, img1[y][x], e1); end
        checks++; if (img2[y][x] !== e2) begin failures++; $display("FAIL geom_lw2 x=%0d y=%0d got=%h exp=%h", x, y, img2[y][x], e2); end
      end
    checks++; if (cnt1 !== 3'd1) begin failures++; $display("FAIL geom_cnt1 got=%0d exp=1", cnt1); end
    checks++; if (cnt2 !== 3'd1) begin failures++; $display("FAIL geom_cnt2 got=%0d exp=1", cnt2); end
    checks++; if (lat_err !== 0) begin failures++; $display("FAIL geom_latency got=%0d exp=0", lat_err); end
  endtask

  task automatic test_disable;
    set_box1(1'b0, 10'd2, 10'd5);
    lat_err = 0;
    run_frame(-1, 10'd0, -1);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 16; x++) begin
        checks++; if (img1[y][x] !== pix(x, y)) begin failures++; $display("FAIL dis_lw1 x=%0d y=%0d got=%h exp=%h", x, y, img1[y][x], pix(x, y)); end
        checks++; if (img2[y][x] !== pix(x, y)) begin failures++; $display("FAIL dis_lw2 x=%0d y=%0d got=%h exp=%h", x, y, img2[y][x], pix(x, y)); end
      end
    checks++; if (cnt1 !== 3'd0) begin failures++; $display("FAIL dis_cnt1 got=%0d exp=0", cnt1); end
    checks++; if (cnt2 !== 3'd0) begin failures++; $display("FAIL dis_cnt2 got=%0d exp=0", cnt2); end
    checks++; if (lat_err !== 0) begin failures++; $display("FAIL dis_latency got=%0d exp=0", lat_err); end
  endtask

  task automatic test_invalid;
    logic [15:0] e1, e2;
    set_box1(1'b1, 10'd2, 10'd5);
    char_line_left[19:10]  = 10'd9;  char_line_right[19:10] = 10'd9;
    char_line_left[29:20]  = 10'd3;  char_line_right[29:20] = 10'd16;
    char_line_left[39:30]  = 10'd4;  char_line_right[39:30] = 10'd10;
    run_frame(-1, 10'd0, -1);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 16; x++) begin
        e1 = (rc(x, y, 2, 5, 1, 1) || rc(x, y, 2, 5, 6, 6) || rc(x, y, 2, 2, 1, 6) || rc(x, y, 5, 5, 1, 6) ||
              rc(x, y, 4, 10, 1, 1) || rc(x, y, 4, 10, 6, 6) || rc(x, y, 4, 4, 1, 6) || rc(x, y, 10, 10, 1, 6)) ? BOX : pix(x, y);
        e2 = (rc(x, y, 2, 5, 1, 6) || rc(x, y, 4, 10, 1, 2) || rc(x, y, 4, 10, 5, 6) ||
              rc(x, y, 4, 5, 1, 6) || rc(x, y, 9, 10, 1, 6)) ? BOX : pix(x, y);
        checks++; if (img1[y][x] !== e1) begin failures++; $display("FAIL inval_lw1 x=%0d y=%0d got=%h exp=%h", x, y, img1[y][x], e1); end
        checks++; if (img2[y][x] !== e2) begin failures++; $display("FAIL inval_lw2 x=%0d y=%0d got=%h exp=%h", x, y, img2[y][x], e2); end
      end
    checks++; if (cnt1 !== 3'd2) begin failures++; $display("FAIL inval_cnt1 got=%0d exp=2", cnt1); end
    checks++; if (cnt2 !== 3'd2) begin failures++; $display("FAIL inval_cnt2 got=%0d exp=2", cnt2); end
    // Bottom row equal to the image height invalidates every box.
    vertical_end = 10'd8;
    run_frame(-1, 10'd0, -1);
    checks++; if (cnt1 !== 3'd0) begin failures++; $display("FAIL vend_cnt1 got=%0d exp=0", cnt1); end
    checks++; if (img1[1][2] !== pix(2, 1)) begin failures++; $display("FAIL vend_px got=%h exp=%h", img1[1][2], pix(2, 1)); end
  endtask

  task automatic test_midframe;
    logic [15:0] e1;
    set_box1(1'b1, 10'd2, 10'd12);
    run_frame(3, 10'd7, -1);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 16; x++) begin
        e1 = (rc(x, y, 2, 12, 1, 1) || rc(x, y, 2, 12, 6, 6) || rc(x, y, 2, 2, 1, 6) || rc(x, y, 12, 12, 1, 6)) ? BOX : pix(x, y);
        checks++; if (img1[y][x] !== e1) begin failures++; $display("FAIL mid_cur x=%0d y=%0d got=%h exp=%h", x, y, img1[y][x], e1); end
      end
    run_frame(-1, 10'd0, -1);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 16; x++) begin
        e1 = (rc(x, y, 7, 12, 1, 1) || rc(x, y, 7, 12, 6, 6) || rc(x, y, 7, 7, 1, 6) || rc(x, y, 12, 12, 1, 6)) ? BOX : pix(x, y);
        checks++; if (img1[y][x] !== e1) begin failures++; $display("FAIL mid_next x=%0d y=%0d got=%h exp=%h", x, y, img1[y][x], e1); end
      end
  endtask

  task automatic test_thickness;
    logic [15:0] e1, e2;
    set_box1(1'b1, 10'd2, 10'd4);
    lat_err = 0;
    run_frame(-1, 10'd0, -1);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 16; x++) begin
        e1 = (rc(x, y, 2, 4, 1, 1) || rc(x, y, 2, 4, 6, 6) || rc(x, y, 2, 2, 1, 6) || rc(x, y, 4, 4, 1, 6)) ? BOX : pix(x, y);
        e2 = rc(x, y, 2, 4, 1, 6) ? BOX : pix(x, y);
        checks++; if (img1[y][x] !== e1) begin failures++; $display("FAIL thick_lw1 x=%0d y=%0d got=%h exp=%h", x, y, img1[y][x], e1); end
        checks++; if (img2[y][x] !== e2) begin failures++; $display("FAIL thick_lw2 x=%0d y=%0d got=%h exp=%h", x, y, img2[y][x], e2); end
      end
    checks++; if (lat_err !== 0) begin failures++; $display("FAIL thick_latency got=%0d exp=0", lat_err); end
  endtask

  task automatic test_reset_midframe;
    logic [15:0] e1;
    set_box1(1'b1, 10'd2, 10'd5);
    rst_snap = '1;
    lat_err  = 0;
    run_frame(-1, 10'd0, 4);
    checks++; if (rst_snap !== 44'd0) begin failures++; $display("FAIL rst_async got=%h exp=0", rst_snap); end
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 16; x++) begin
        e1 = (y < 4 && (rc(x, y, 2, 5, 1, 1) || rc(x, y, 2, 2, 1, 6) || rc(x, y, 5, 5, 1, 6))) ? BOX : pix(x, y);
        if (y != 4) begin
          checks++; if (img1[y][x] !== e1) begin failures++; $display("FAIL rst_frame x=%0d y=%0d got=%h exp=%h", x, y, img1[y][x], e1); end
        end
      end
    checks++; if (cnt1 !== 3'd0) begin failures++; $display("FAIL rst_cnt1 got=%0d exp=0", cnt1); end
    checks++; if (cnt2 !== 3'd0) begin failures++; $display("FAIL rst_cnt2 got=%0d exp=0", cnt2); end
    checks++; if (lat_err !== 0) begin failures++; $display("FAIL rst_latency got=%0d exp=0", lat_err); end
    run_frame(-1, 10'd0, -1);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 16; x++) begin
        e1 = (rc(x, y, 2, 5, 1, 1) || rc(x, y, 2, 5, 6, 6) || rc(x, y, 2, 2, 1, 6) || rc(x, y, 5, 5, 1, 6)) ? BOX : pix(x, y);
        checks++; if (img1[y][x] !== e1) begin failures++; $display("FAIL rst_next x=%0d y=%0d got=%h exp=%h", x, y, img1[y][x], e1); end
      end
    checks++; if (cnt1 !== 3'd1) begin failures++; $display("FAIL rst_next_cnt got=%0d exp=1", cnt1); end
  endtask

  initial begin
    in_if.vsync = 1'b0;
    in_if.href  = 1'b0;
    in_if.clken = 1'b0;
    in_if.data  = 16'h0000;
    test_reset;
    test_geometry;
    test_disable;
    test_invalid;
    test_midframe;
    test_thickness;
    test_reset_midframe;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/char_box_overlay.md
Name: char_box_overlay

Overview:
- Consumer of the seven per-character column boundaries and the projection row window produced by the character vertical projection stage.
- Draws a rectangular outline around each segmented character on the RGB565 display stream, so the segmentation can be checked on screen.
- Sits between the video pipeline output and the display/VGA writer; it is a pure pass-through when disabled.

Parameters:
IMG_HDISP, 10'd640, active pixels per line
IMG_VDISP, 10'd480, active lines per frame
LINE_W, 2, outline thickness in pixels, legal range 1..4
BOX_COLOR, 16'hF800, RGB565 outline colour (red)

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous active-high reset
overlay_en  in  1  1 = draw outlines; sampled per frame
per_frame_vsync  in  1  input frame sync
per_frame_href  in  1  input line valid
per_frame_clken  in  1  input pixel strobe
per_img_data  in  16  input RGB565 pixel
vertical_start  in  10  box top row
vertical_end  in  10  box bottom row
char_line_left  in  70  packed left columns; char k (1..7) at bits [10k-1:10k-10]
char_line_right  in  70  packed right columns, same packing
post_frame_vsync  out  1  delayed vsync
post_frame_href  out  1  delayed href
post_frame_clken  out  1  delayed clken
post_img_data  out  16  output pixel
box_valid_cnt  out  3  number of valid boxes drawn in the current frame

Behaviour:
- Reset (async, rst=1): all outputs 0, counters 0, shadow registers 0, overlay disabled.
- Shadow latch on vsync rising edge (vsync high, registered vsync low):
  - Capture overlay_en, vertical_start/end, all 14 boundaries.
  - Compute per-box valid[k] = (left<right) && (right<IMG_HDISP) && (vertical_start<vertical_end) && (vertical_end<IMG_VDISP).
  - Input changes mid-frame have no effect until the next vsync rising edge.
- box_valid_cnt:
  - Updates one cycle after the shadow latch to popcount(valid).
  - Forced to 0 when the latched overlay_en=0.
- Coordinates:
  - x_cnt increments on each clken and clears on href falling edge.
  - y_cnt increments on href falling edge and clears on vsync rising edge.
  - x_cnt saturates at 1023 and never wraps; y_cnt likewise.
  - Coordinates label the pixel presented with clken.
- Hit test, stage 1 (registered), for box k, with T=vertical_start, B=vertical_end, L=left_k, R=right_k:
  - hband = (y in [T, T+LINE_W-1] or y in [B-LINE_W+1, B]) and x in [L, R].
  - vband = (x in [L, L+LINE_W-1] or x in [R-LINE_W+1, R]) and y in [T, B].
  - hit = OR over k of valid[k] && (hband || vband).
  - All comparisons are 11-bit unsigned, so T+LINE_W-1 cannot overflow.
  - Bands of boxes narrower than 2*LINE_W overlap; the box is then drawn solid. This is legal.
- Stage 2 (registered): post_img_data = (hit && overlay_en_latched) ? BOX_COLOR : pixel delayed by 2.
- Latency: exactly 2 clk. vsync, href and clken are delayed by 2 through the same pipeline. Output is registered every clk regardless of clken, so gaps in clken are preserved.
- Adjacent or overlapping boxes need no arbitration; the OR gives a single colour.
- A vsync rising edge while href is high (truncated frame): shadow latch and y_cnt clear still happen; the pipeline contents drain unchanged.
- Reset asserted mid-frame: outputs go to 0 immediately. After release, no outlines are drawn until the next vsync rising edge latches new values.

Test Plan:
- Geometry: IMG 16x8, LINE_W=1, T=1, B=6, box1 L=2 R=5, others L=R=0, overlay_en=1, data=16'h1234 → BOX_COLOR at rows 1 and 6 for x 2..5, and at x=2 and x=5 for rows 1..6; 16'h1234 elsewhere; box_valid_cnt=1; output 2 clk after input.
- Disable: same frame with overlay_en=0 → output equals input delayed 2; box_valid_cnt=0.
- Invalid boxes: box2 L=9 R=9 and box3 R=16 → not drawn; box_valid_cnt counts only box1.
- Mid-frame update: change box1 L to 7 during line 3 → current frame keeps L=2; next frame draws at L=7.
- Thickness: LINE_W=2, box L=2 R=4 → columns 2..4 filled for rows 1..6; rows 1, 2, 5, 6 filled for x 2..4.
- Async reset during line 4 → all outputs 0 on the same edge; after release, first frame shows input passthrough until the following vsync latch.
